// File: rtl/act_tile_feeder.sv
// Activation tile buffer feeding the systolic array's skew delay lines.
// Loads R rows, streams them on start, then emits L-1 zero flush cycles.
module act_tile_feeder #(
   parameter int B = 8,
   parameter int L = 4,
   parameter int R = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [L*B-1:0] in_data,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           start,
   input  logic           reuse,
   output logic [L*B-1:0] out_data,
   output logic           out_valid,
   output logic           out_last,
   output logic           busy,
   output logic           done
);
   typedef enum logic [1:0] {LOAD, READY, STREAM, FLUSH} state_t;

   localparam int RW = $clog2(R);
   localparam int FW = (L > 2) ? $clog2(L) : 1;
   localparam logic [RW-1:0] R_LAST  = RW'(R - 1);
   localparam logic [FW-1:0] FL_LAST = (L > 1) ? FW'(L - 2) : '0;

   state_t          state, nstate;
   logic [RW-1:0]   wr_cnt, wr_n, rd_cnt, rd_n;
   logic [FW-1:0]   fl_cnt, fl_n;
   logic            reuse_q, reuse_n, done_n, we;
   logic [L*B-1:0]  mem [R];

   always_comb begin
      nstate  = state;
      wr_n    = wr_cnt;
      rd_n    = rd_cnt;
      fl_n    = fl_cnt;
      reuse_n = reuse_q;
      done_n  = 1'b0;
      we      = 1'b0;
      case (state)
         LOAD: begin
            // start is deliberately not looked at here, even on the final row
            if (in_valid && in_ready) begin
               we = 1'b1;
               if (wr_cnt == R_LAST) begin
                  wr_n   = '0;
                  nstate = READY;
               end else begin
                  wr_n = wr_cnt + 1'b1;
               end
            end
         end
         READY: begin
            if (start) begin
               reuse_n = reuse;
               rd_n    = '0;
               nstate  = STREAM;
            end
         end
         STREAM: begin
            if (rd_cnt == R_LAST) begin
               if (L > 1) begin
                  fl_n   = '0;
                  nstate = FLUSH;
               end else begin
                  done_n = 1'b1;
                  nstate = reuse_q ? READY : LOAD;
               end
            end else begin
               rd_n = rd_cnt + 1'b1;
            end
         end
         FLUSH: begin
            if (fl_cnt == FL_LAST) begin
               done_n = 1'b1;
               nstate = reuse_q ? READY : LOAD;
            end else begin
               fl_n = fl_cnt + 1'b1;
            end
         end
         default: nstate = LOAD;
      endcase
   end

   // Buffer is intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (we) mem[wr_cnt] <= in_data;
   end

   // Outputs are registered from the next-state view so row i lands in t+1+i.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         fl_cnt    <= '0;
         reuse_q   <= 1'b0;
         in_ready  <= 1'b1;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= nstate;
         wr_cnt    <= wr_n;
         rd_cnt    <= rd_n;
         fl_cnt    <= fl_n;
         reuse_q   <= reuse_n;
         in_ready  <= (nstate == LOAD);
         out_data  <= (nstate == STREAM) ? mem[rd_n] : '0;
         out_valid <= (nstate == STREAM);
         out_last  <= (nstate == STREAM) && (rd_n == R_LAST);
         busy      <= (nstate == STREAM) || (nstate == FLUSH);
         done      <= done_n;
      end
   end
endmodule

// File: tb/tb_act_tile_feeder.sv
// Directed bench for act_tile_feeder: default (L=4,R=8) and corner (L=1,R=3) instances.
module tb_act_tile_feeder;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid, start, reuse;
   logic        in_ready, out_valid, out_last, busy, done;
   logic [31:0] out_data;
   logic [7:0]  in_data1;
   logic        in_valid1, start1, reuse1;
   logic        in_ready1, out_valid1, out_last1, busy1, done1;
   logic [7:0]  out_data1;
   int          npass = 0, ntotal = 0;

   always #5 clk = ~clk;

   act_tile_feeder #(.B(8), .L(4), .R(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .start(start), .reuse(reuse), .out_data(out_data), .out_valid(out_valid),
      .out_last(out_last), .busy(busy), .done(done));

   act_tile_feeder #(.B(8), .L(1), .R(3)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .start(start1), .reuse(reuse1), .out_data(out_data1), .out_valid(out_valid1),
      .out_last(out_last1), .busy(busy1), .done(done1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] row(input int i, input logic [31:0] m);
      return {8'(i + 1), 8'(i + 2), 8'(i + 3), 8'(i + 4)} ^ m;
   endfunction

   task automatic load8(input logic [31:0] m);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = row(i, m);
         tick();
      end
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   // Starts at cycle t (the current cycle) and checks through the done cycle t+12.
   task automatic stream8(input bit re, input logic [31:0] m, input bit poke);
      start = 1'b1;
      reuse = re;
      tick();
      start = 1'b0;
      reuse = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("row%0d_valid", i), {31'b0, out_valid}, 32'd1);
         chk($sformatf("row%0d_data", i), out_data, row(i, m));
         chk($sformatf("row%0d_last", i), {31'b0, out_last}, {31'b0, i == 7});
         chk($sformatf("row%0d_busy", i), {31'b0, busy}, 32'd1);
         chk($sformatf("row%0d_done", i), {31'b0, done}, 32'd0);
         start = poke && (i == 3);
         tick();
         start = 1'b0;
      end
      for (int f = 0; f < 3; f++) begin
         chk($sformatf("flush%0d_valid", f), {31'b0, out_valid}, 32'd0);
         chk($sformatf("flush%0d_data", f), out_data, 32'd0);
         chk($sformatf("flush%0d_busy", f), {31'b0, busy}, 32'd1);
         chk($sformatf("flush%0d_done", f), {31'b0, done}, 32'd0);
         start = poke && (f == 1);
         tick();
         start = 1'b0;
      end
      chk("done_pulse", {31'b0, done}, 32'd1);
      chk("done_busy", {31'b0, busy}, 32'd0);
      chk("done_valid", {31'b0, out_valid}, 32'd0);
      chk("done_in_ready", {31'b0, in_ready}, {31'b0, !re});
   endtask

   initial begin
      int idx, k;
      rst = 1'b1; in_data = '0; in_valid = 0; start = 0; reuse = 0;
      in_data1 = '0; in_valid1 = 0; start1 = 0; reuse1 = 0;
      tick(); tick();
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      rst = 1'b0;
      tick();

      // Gapped load; start pulses during LOAD (after 3 rows and with the last row) are ignored.
      idx = 0; k = 0;
      while (idx < 8) begin
         in_valid = (k % 3 != 1);
         in_data  = in_valid ? row(idx, 32'h0) : 32'hDEADBEEF;
         start    = (idx == 3 && !in_valid) || (idx == 7 && in_valid);
         tick();
         if (in_valid) idx++;
         k++;
         if (idx < 8) chk($sformatf("load_ready%0d", k), {31'b0, in_ready}, 32'd1);
         chk($sformatf("load_busy%0d", k), {31'b0, busy}, 32'd0);
      end
      start = 0;
      chk("full_in_ready", {31'b0, in_ready}, 32'd0);
      chk("full_out_valid", {31'b0, out_valid}, 32'd0);
      in_valid = 1'b1; in_data = 32'hFFFFFFFF;
      tick();
      in_valid = 1'b0; in_data = '0;
      chk("ninth_in_ready", {31'b0, in_ready}, 32'd0);
      chk("ninth_busy", {31'b0, busy}, 32'd0);
      tick();

      // Replay with reuse, back-to-back start in the done cycle, starts mid-stream ignored.
      stream8(1'b1, 32'h0, 1'b1);
      stream8(1'b0, 32'h0, 1'b0);
      tick();
      chk("after_done", {31'b0, done}, 32'd0);
      chk("after_in_ready", {31'b0, in_ready}, 32'd1);

      // Reset in cycle t+4 of a stream.
      load8(32'h10101010);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("pre_rst_data", out_data, row(3, 32'h10101010));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("mid_rst_done", {31'b0, done}, 32'd0);
      chk("mid_rst_last", {31'b0, out_last}, 32'd0);
      tick();
      chk("post_rst_done", {31'b0, done}, 32'd0);
      load8(32'hA5A5A5A5);
      stream8(1'b0, 32'hA5A5A5A5, 1'b0);

      // Corner instance L=1, R=3: no flush, done at t+4.
      for (int i = 0; i < 3; i++) begin
         in_valid1 = 1'b1;
         in_data1  = 8'(8'h11 * (i + 1));
         tick();
      end
      in_valid1 = 1'b0;
      chk("c_in_ready", {31'b0, in_ready1}, 32'd0);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("c_row%0d_valid", i), {31'b0, out_valid1}, 32'd1);
         chk($sformatf("c_row%0d_data", i), {24'b0, out_data1}, 32'(8'h11 * (i + 1)));
         chk($sformatf("c_row%0d_last", i), {31'b0, out_last1}, {31'b0, i == 2});
         chk($sformatf("c_row%0d_busy", i), {31'b0, busy1}, 32'd1);
         chk($sformatf("c_row%0d_done", i), {31'b0, done1}, 32'd0);
         tick();
      end
      chk("c_done", {31'b0, done1}, 32'd1);
      chk("c_done_valid", {31'b0, out_valid1}, 32'd0);
      chk("c_done_busy", {31'b0, busy1}, 32'd0);
      chk("c_done_in_ready", {31'b0, in_ready1}, 32'd1);
      tick();
      chk("c_after_done", {31'b0, done1}, 32'd0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule

// File: doc/act_tile_feeder.md
Name: act_tile_feeder

Overview:
- Activation tile buffer that sits directly upstream of the per-lane delay lines that skew data into the systolic PE array.
- Accepts R row-vectors of L lanes x B bits over a valid/ready handshake and stores them.
- On a start pulse, streams the rows out one per cycle, then emits L-1 zero flush cycles so the skewed downstream lanes drain.
- Supports tile reuse (weight-stationary mode): the same tile can be replayed without a reload.

Parameters:
- B, 8, bit width of one lane element
- L, 4, number of lanes (width of the PE array edge; delay-line count downstream)
- R, 8, rows per tile (buffer depth); R >= 2

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  L*B  row-vector; lane k at bits [k*B+B-1 : k*B]
- in_valid  in  1  in_data valid
- in_ready  out  1  feeder accepts a row this cycle
- start  in  1  single-cycle request to stream the stored tile
- reuse  in  1  sampled with an accepted start; 1 = keep tile for replay
- out_data  out  L*B  row to the delay lines; all zero when out_valid=0
- out_valid  out  1  out_data carries a tile row
- out_last  out  1  high with the final row (row R-1)
- busy  out  1  high in STREAM or FLUSH
- done  out  1  one-cycle pulse after the tile has fully drained

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high. All outputs are registered.
- Reset values: in_ready=1 from the first cycle after reset (state LOAD). out_data=0, out_valid=0, out_last=0, busy=0, done=0. Row counter=0, reuse latch=0.
- Buffer contents are not cleared by reset.
- FSM states: LOAD, READY, STREAM, FLUSH.
- LOAD:
  - in_ready=1.
  - A handshake (in_valid & in_ready) writes in_data to buffer[wr_cnt] and increments wr_cnt.
  - The write of row R-1 moves the FSM to READY and resets wr_cnt to 0.
  - start is ignored in LOAD.
- READY:
  - in_ready=0.
  - start=1 latches reuse, clears rd_cnt, and moves to STREAM.
  - in_valid is ignored.
- STREAM:
  - If start is sampled in cycle t, row i is on out_data with out_valid=1 in cycle t+1+i, for i=0..R-1.
  - out_last=1 only in cycle t+R.
  - After row R-1 the FSM goes to FLUSH; if L==1 it skips FLUSH.
- FLUSH:
  - L-1 cycles (t+R+1 .. t+R+L-1) with out_valid=0 and out_data=0.
- done:
  - Pulses high for exactly cycle t+R+L, for every L including L=1.
  - In that same cycle the FSM is in READY if the latched reuse=1, otherwise in LOAD.
- busy=1 exactly during cycles t+1 .. t+R+L-1.
- start in STREAM or FLUSH is ignored; it is not queued.
- Back-to-back replay: a start in the done cycle (state READY, reuse path) is accepted. Minimum replay period is R+L cycles.
- Tile reload is only possible after a non-reuse pass. There is no path from READY to LOAD other than reset.
- Counters wr_cnt/rd_cnt are clog2(R) bits. Terminal values are compared against R-1, not left to wrap, so non-power-of-2 R is supported.
- Flush counter: clog2(L) bits, terminal value L-2.
- Reset mid-operation (any state): next cycle is LOAD with wr_cnt=0.
  - out_valid/out_last/busy drop to 0 with no done pulse.
  - Any partially loaded tile is discarded.
- Simultaneous in_valid and start in LOAD: only the write occurs. This holds even for the final row; start must come in a later cycle.
- Data passes through unmodified: no arithmetic, no sign handling, bit-exact lane ordering.

Test Plan:
1. Load and stream (B=8, L=4, R=8): load rows 0x01020304 .. 0x08090A0B with in_valid held; start at cycle t, reuse=0.
   -> rows appear in cycles t+1..t+8 in order; out_last only at t+8; zeros with out_valid=0 at t+9..t+11; done at t+12; in_ready=1 at t+12.
2. Backpressure and gaps: drive in_valid 1,0,1,1,0,... over the load.
   -> exactly 8 rows captured; in_ready drops the cycle after the 8th handshake; a 9th in_valid is not accepted and does not alter the stored tile.
3. Reuse: start with reuse=1, then start again in the done cycle with reuse=0.
   -> two identical 8-row bursts 12 cycles apart; after the second done, in_ready=1.
4. Ignored start: pulse start during LOAD (after 3 rows) and during STREAM.
   -> no output; the stream is not restarted or extended; done count = 1.
5. Reset mid-stream: assert rst in cycle t+4.
   -> cycle t+5: out_valid=0, busy=0, in_ready=1, no done; a fresh 8-row load then streams correctly.
6. Corner parameters L=1, R=3: load 3 rows, start at t.
   -> rows at t+1..t+3, out_last at t+3, no flush, done at t+4.
